// File: rtl/bw_io_jp_bsr_seq.sv
// Sequencer for the IO boundary-scan chain of jp sstl/odt oe-scan cells.
// Runs one command at a time, generating capture/shift/update strobes and the
// chain-wide mode_ctl / bsr_hiz_l controls, and returns the captured chain data.
module bw_io_jp_bsr_seq #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 arst_l,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [1:0]           req_op,
  input  logic [CHAIN_LEN-1:0] req_wdata,
  output logic                 rsp_vld,
  output logic [CHAIN_LEN-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 bsr_si,
  input  logic                 bsr_so,
  output logic                 shift_dr,
  output logic                 clock_dr,
  output logic                 update_dr,
  output logic                 mode_ctl,
  output logic                 bsr_hiz_l
);

  localparam logic [1:0] OpSample  = 2'b00;
  localparam logic [1:0] OpExtest  = 2'b01;
  localparam logic [1:0] OpHighz   = 2'b10;
  localparam logic [1:0] OpRelease = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShSetup,
    StShEdge,
    StUpdate,
    StDone
  } state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic [1:0]           r_op;
  logic [CHAIN_LEN-1:0] r_sreg;
  logic [CHAIN_LEN-1:0] w_sreg_d;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic                 r_shift_dr;
  logic                 r_clock_dr;
  logic                 r_update_dr;
  logic                 r_bsr_si;
  logic                 r_mode_ctl;
  logic                 r_bsr_hiz_l;
  logic                 r_rsp_vld;
  logic [CHAIN_LEN-1:0] r_rsp_rdata;
  logic                 w_accept;
  logic                 w_last_bit;
  logic                 w_chain_op;

  assign w_accept   = req_vld && (r_state == StIdle);
  assign w_last_bit = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_chain_op = (req_op == OpSample) || (req_op == OpExtest);

  // Next-state decode; only an accepted command leaves IDLE
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (w_accept) w_state_d = w_chain_op ? StCapture : StDone;
      StCapture: w_state_d = StShSetup;
      StShSetup: w_state_d = StShEdge;
      StShEdge: begin
        if (!w_last_bit)             w_state_d = StShSetup;
        else if (r_op == OpExtest)   w_state_d = StUpdate;
        else                         w_state_d = StDone;
      end
      StUpdate:  w_state_d = StDone;
      StDone:    w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Shift register next value: load on accept, shift chain output in at each shift edge
  always_comb begin
    w_sreg_d = r_sreg;
    if (w_accept) begin
      w_sreg_d = req_wdata;
    end else if (r_state == StShEdge) begin
      w_sreg_d = {bsr_so, r_sreg[CHAIN_LEN-1:1]};
    end
  end

  // Datapath state: shift register, latched op and bit counter
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_sreg    <= '0;
      r_op      <= OpSample;
      r_bit_cnt <= '0;
    end else begin
      r_sreg <= w_sreg_d;
      if (w_accept) begin
        r_op      <= req_op;
        r_bit_cnt <= '0;
      end else if (r_state == StShEdge) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // FSM with outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_state     <= StIdle;
      r_shift_dr  <= 1'b0;
      r_clock_dr  <= 1'b0;
      r_update_dr <= 1'b0;
      r_bsr_si    <= 1'b0;
      r_mode_ctl  <= 1'b0;
      r_bsr_hiz_l <= 1'b1;
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_shift_dr  <= (w_state_d == StShSetup) || (w_state_d == StShEdge);
      r_clock_dr  <= (w_state_d == StCapture) || (w_state_d == StShEdge);
      r_update_dr <= (w_state_d == StUpdate);
      r_rsp_vld   <= (w_state_d == StDone);

      // bsr_si only changes on entry to SH_SETUP and is held through SH_EDGE
      case (w_state_d)
        StShSetup: r_bsr_si <= w_sreg_d[0];
        StShEdge:  r_bsr_si <= r_bsr_si;
        default:   r_bsr_si <= 1'b0;
      endcase

      if (r_state == StUpdate) begin
        r_mode_ctl <= 1'b1;
      end else if (w_accept && (req_op == OpRelease)) begin
        r_mode_ctl <= 1'b0;
      end

      if (w_accept && (req_op == OpHighz)) begin
        r_bsr_hiz_l <= 1'b0;
      end else if (w_accept && (req_op == OpRelease)) begin
        r_bsr_hiz_l <= 1'b1;
      end

      // Only chain ops reach DONE via SH_EDGE/UPDATE; HIGHZ/RELEASE keep the old data
      if ((w_state_d == StDone) && ((r_state == StShEdge) || (r_state == StUpdate))) begin
        r_rsp_rdata <= w_sreg_d;
      end
    end
  end

  assign req_rdy   = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign shift_dr  = r_shift_dr;
  assign clock_dr  = r_clock_dr;
  assign update_dr = r_update_dr;
  assign bsr_si    = r_bsr_si;
  assign mode_ctl  = r_mode_ctl;
  assign bsr_hiz_l = r_bsr_hiz_l;
  assign rsp_vld   = r_rsp_vld;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_bw_io_jp_bsr_seq.sv
// Directed bench for bw_io_jp_bsr_seq with a behavioural model of the BSR chain.
module tb_bw_io_jp_bsr_seq;

  localparam int N = 64;
  localparam logic [1:0] OpSample  = 2'b00;
  localparam logic [1:0] OpExtest  = 2'b01;
  localparam logic [1:0] OpHighz   = 2'b10;
  localparam logic [1:0] OpRelease = 2'b11;

  logic         clk;
  logic         arst_l;
  logic         req_vld;
  logic         req_rdy;
  logic [1:0]   req_op;
  logic [N-1:0] req_wdata;
  logic         rsp_vld;
  logic [N-1:0] rsp_rdata;
  logic         busy;
  logic         bsr_si;
  logic         bsr_so;
  logic         shift_dr;
  logic         clock_dr;
  logic         update_dr;
  logic         mode_ctl;
  logic         bsr_hiz_l;

  logic [N-1:0] chain;
  logic         load_en;
  logic [N-1:0] load_val;
  logic         last_setup_si;

  int n_checks = 0;
  int n_pass   = 0;
  int mon_viol = 0;
  int n_cap    = 0;
  int n_sh     = 0;
  int n_upd    = 0;

  bw_io_jp_bsr_seq #(
    .CHAIN_LEN (N),
    .CNT_W     (7)
  ) dut (
    .clk       (clk),
    .arst_l    (arst_l),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_wdata (req_wdata),
    .rsp_vld   (rsp_vld),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .bsr_si    (bsr_si),
    .bsr_so    (bsr_so),
    .shift_dr  (shift_dr),
    .clock_dr  (clock_dr),
    .update_dr (update_dr),
    .mode_ctl  (mode_ctl),
    .bsr_hiz_l (bsr_hiz_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain model: serial in at the top, bit0 is the chain end driving bsr_so
  assign bsr_so = chain[0];
  always @(posedge clk) begin
    if (load_en) begin
      chain <= load_val;
    end else if (arst_l && shift_dr && clock_dr) begin
      chain <= {bsr_si, chain[N-1:1]};
    end
  end

  // Strobe-rule monitor and pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (arst_l) begin
      if (clock_dr && update_dr) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL strobe_overlap: clock_dr=%b update_dr=%b, required not both 1",
                 clock_dr, update_dr);
      end
      if (update_dr && shift_dr) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL update_in_shift: update_dr=%b shift_dr=%b, required shift_dr=0",
                 update_dr, shift_dr);
      end
      if (shift_dr && clock_dr && (bsr_si !== last_setup_si)) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL si_stable: bsr_si=%b, required %b", bsr_si, last_setup_si);
      end
      if (!shift_dr && (bsr_si !== 1'b0)) begin
        mon_viol <= mon_viol + 1;
        $display("FAIL si_idle: bsr_si=%b, required 0", bsr_si);
      end
      if (shift_dr && !clock_dr) last_setup_si <= bsr_si;
      if (clock_dr && shift_dr) n_sh <= n_sh + 1;
      if (clock_dr && !shift_dr) n_cap <= n_cap + 1;
      if (update_dr) n_upd <= n_upd + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns at cycle T+1
  task automatic issue(input logic [1:0] op, input logic [N-1:0] wd);
    req_vld   = 1'b1;
    req_op    = op;
    req_wdata = wd;
    step();
    req_vld   = 1'b0;
  endtask

  task automatic test_reset();
    arst_l   = 1'b0;
    load_val = '0;
    load_en  = 1'b1;
    repeat (3) step();
    load_en = 1'b0;
    n_checks++;
    if ({shift_dr, clock_dr, update_dr, bsr_si, mode_ctl, rsp_vld} !== 6'b0)
      $display("FAIL reset_strobes: got %b, required 000000",
               {shift_dr, clock_dr, update_dr, bsr_si, mode_ctl, rsp_vld});
    else n_pass++;
    n_checks++;
    if ({bsr_hiz_l, req_rdy, busy} !== 3'b110)
      $display("FAIL reset_ctl: hiz_l/rdy/busy=%b, required 110", {bsr_hiz_l, req_rdy, busy});
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== '0) $display("FAIL reset_rdata: got %h, required 0", rsp_rdata);
    else n_pass++;
    arst_l = 1'b1;
    step();
  endtask

  task automatic test_sample();
    int off;
    int sh0;
    logic mode_seen;
    load_val = 64'hA5A5_A5A5_A5A5_A5A5;
    load_en  = 1'b1;
    step();
    load_en   = 1'b0;
    sh0       = n_sh;
    mode_seen = 1'b0;
    issue(OpSample, 64'h0123_4567_89AB_CDEF);
    off = 1;
    n_checks++;
    if ({clock_dr, shift_dr} !== 2'b10)
      $display("FAIL sample_capture: clock_dr/shift_dr=%b, required 10", {clock_dr, shift_dr});
    else n_pass++;
    step();
    off = 2;
    n_checks++;
    if ({shift_dr, clock_dr, bsr_si} !== 3'b101)
      $display("FAIL sample_setup: shift/clock/si=%b, required 101", {shift_dr, clock_dr, bsr_si});
    else n_pass++;
    while (rsp_vld !== 1'b1 && off < 300) begin
      if (mode_ctl) mode_seen = 1'b1;
      step();
      off++;
    end
    n_checks++;
    if (off != 130) $display("FAIL sample_latency: rsp_vld at T+%0d, required T+130", off);
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 64'hA5A5_A5A5_A5A5_A5A5)
      $display("FAIL sample_rdata: got %h, required a5a5a5a5a5a5a5a5", rsp_rdata);
    else n_pass++;
    n_checks++;
    if (mode_seen || mode_ctl !== 1'b0)
      $display("FAIL sample_mode: mode_ctl rose=%b now=%b, required 0", mode_seen, mode_ctl);
    else n_pass++;
    step();
    n_checks++;
    if ({rsp_vld, req_rdy} !== 2'b01)
      $display("FAIL sample_done: rsp_vld/req_rdy=%b, required 01", {rsp_vld, req_rdy});
    else n_pass++;
    n_checks++;
    if (chain !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL sample_chain: got %h, required 0123456789abcdef", chain);
    else n_pass++;
    n_checks++;
    if (n_sh - sh0 != 64) $display("FAIL sample_shifts: got %0d, required 64", n_sh - sh0);
    else n_pass++;
  endtask

  task automatic test_extest();
    int off;
    int upd_off;
    int mode_off;
    int sh0;
    int cap0;
    int upd0;
    sh0      = n_sh;
    cap0     = n_cap;
    upd0     = n_upd;
    upd_off  = 0;
    mode_off = 0;
    issue(OpExtest, 64'hFEDC_BA98_7654_3210);
    off = 1;
    while (rsp_vld !== 1'b1 && off < 300) begin
      if (update_dr === 1'b1 && upd_off == 0) upd_off = off;
      if (mode_ctl === 1'b1 && mode_off == 0) mode_off = off;
      step();
      off++;
    end
    if (mode_ctl === 1'b1 && mode_off == 0) mode_off = off;
    n_checks++;
    if (off != 131) $display("FAIL extest_latency: rsp_vld at T+%0d, required T+131", off);
    else n_pass++;
    n_checks++;
    if (upd_off != 130) $display("FAIL extest_update: update_dr at T+%0d, required T+130", upd_off);
    else n_pass++;
    n_checks++;
    if (mode_off != 131) $display("FAIL extest_mode: mode_ctl from T+%0d, required T+131", mode_off);
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL extest_rdata: got %h, required 0123456789abcdef", rsp_rdata);
    else n_pass++;
    n_checks++;
    if ((n_sh - sh0 != 64) || (n_cap - cap0 != 1) || (n_upd - upd0 != 1))
      $display("FAIL extest_pulses: shift=%0d cap=%0d upd=%0d, required 64 1 1",
               n_sh - sh0, n_cap - cap0, n_upd - upd0);
    else n_pass++;
    step();
    n_checks++;
    if (chain !== 64'hFEDC_BA98_7654_3210)
      $display("FAIL extest_chain: got %h, required fedcba9876543210", chain);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sh0;
    int cap0;
    int upd0;
    sh0       = n_sh;
    cap0      = n_cap;
    upd0      = n_upd;
    req_vld   = 1'b1;
    req_op    = OpHighz;
    req_wdata = '1;
    step();
    n_checks++;
    if ({bsr_hiz_l, rsp_vld, req_rdy} !== 3'b010)
      $display("FAIL highz_t1: hiz_l/rsp_vld/rdy=%b, required 010", {bsr_hiz_l, rsp_vld, req_rdy});
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL highz_rdata: got %h, required 0123456789abcdef", rsp_rdata);
    else n_pass++;
    req_op    = OpRelease;
    req_wdata = '0;
    step();
    n_checks++;
    if ({req_rdy, bsr_hiz_l, mode_ctl, rsp_vld} !== 4'b1010)
      $display("FAIL b2b_idle: rdy/hiz_l/mode/rsp_vld=%b, required 1010",
               {req_rdy, bsr_hiz_l, mode_ctl, rsp_vld});
    else n_pass++;
    step();
    req_vld = 1'b0;
    n_checks++;
    if ({bsr_hiz_l, mode_ctl, rsp_vld} !== 3'b101)
      $display("FAIL release_done: hiz_l/mode/rsp_vld=%b, required 101",
               {bsr_hiz_l, mode_ctl, rsp_vld});
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL release_rdata: got %h, required 0123456789abcdef", rsp_rdata);
    else n_pass++;
    step();
    n_checks++;
    if ((n_sh != sh0) || (n_cap != cap0) || (n_upd != upd0))
      $display("FAIL b2b_no_strobes: shift=%0d cap=%0d upd=%0d, required 0 0 0",
               n_sh - sh0, n_cap - cap0, n_upd - upd0);
    else n_pass++;
  endtask

  task automatic test_ignored_req();
    int off;
    int sh0;
    int cap0;
    int upd0;
    sh0  = n_sh;
    cap0 = n_cap;
    upd0 = n_upd;
    issue(OpExtest, 64'hDEAD_BEEF_CAFE_F00D);
    off = 1;
    while (rsp_vld !== 1'b1 && off < 300) begin
      if (off == 50) begin
        n_checks++;
        if (req_rdy !== 1'b0) $display("FAIL busy_rdy: req_rdy=%b, required 0", req_rdy);
        else n_pass++;
        req_vld   = 1'b1;
        req_op    = OpHighz;
        req_wdata = '1;
      end
      if (off == 51) req_vld = 1'b0;
      step();
      off++;
    end
    n_checks++;
    if (off != 131) $display("FAIL ignore_latency: rsp_vld at T+%0d, required T+131", off);
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== 64'hFEDC_BA98_7654_3210)
      $display("FAIL ignore_rdata: got %h, required fedcba9876543210", rsp_rdata);
    else n_pass++;
    n_checks++;
    if ((n_sh - sh0 != 64) || (n_cap - cap0 != 1) || (n_upd - upd0 != 1))
      $display("FAIL ignore_pulses: shift=%0d cap=%0d upd=%0d, required 64 1 1",
               n_sh - sh0, n_cap - cap0, n_upd - upd0);
    else n_pass++;
    n_checks++;
    if ({bsr_hiz_l, mode_ctl} !== 2'b11)
      $display("FAIL ignore_ctl: hiz_l/mode=%b, required 11", {bsr_hiz_l, mode_ctl});
    else n_pass++;
    step();
    n_checks++;
    if (chain !== 64'hDEAD_BEEF_CAFE_F00D)
      $display("FAIL ignore_chain: got %h, required deadbeefcafef00d", chain);
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    logic rsp_seen;
    issue(OpHighz, '0);
    step();
    n_checks++;
    if ({bsr_hiz_l, mode_ctl} !== 2'b01)
      $display("FAIL pre_reset_ctl: hiz_l/mode=%b, required 01", {bsr_hiz_l, mode_ctl});
    else n_pass++;
    issue(OpSample, 64'h1111_2222_3333_4444);
    repeat (39) step();
    #2;
    arst_l = 1'b0;
    #1;
    n_checks++;
    if ({shift_dr, clock_dr, update_dr, bsr_si, rsp_vld} !== 5'b0)
      $display("FAIL midrst_strobes: got %b, required 00000",
               {shift_dr, clock_dr, update_dr, bsr_si, rsp_vld});
    else n_pass++;
    n_checks++;
    if ({bsr_hiz_l, mode_ctl, req_rdy, busy} !== 4'b1010)
      $display("FAIL midrst_ctl: hiz_l/mode/rdy/busy=%b, required 1010",
               {bsr_hiz_l, mode_ctl, req_rdy, busy});
    else n_pass++;
    n_checks++;
    if (rsp_rdata !== '0) $display("FAIL midrst_rdata: got %h, required 0", rsp_rdata);
    else n_pass++;
    repeat (2) step();
    arst_l   = 1'b1;
    rsp_seen = 1'b0;
    for (int i = 0; i < 140; i++) begin
      if (rsp_vld) rsp_seen = 1'b1;
      step();
    end
    n_checks++;
    if (rsp_seen || req_rdy !== 1'b1)
      $display("FAIL midrst_no_rsp: rsp_seen=%b req_rdy=%b, required 0 1", rsp_seen, req_rdy);
    else n_pass++;
  endtask

  initial begin
    req_vld       = 1'b0;
    req_op        = OpSample;
    req_wdata     = '0;
    load_en       = 1'b0;
    load_val      = '0;
    last_setup_si = 1'b0;
    test_reset();
    test_sample();
    test_extest();
    test_back_to_back();
    test_ignored_req();
    test_reset_mid_shift();
    n_checks++;
    if (mon_viol != 0) $display("FAIL strobe_rules: %0d violations, required 0", mon_viol);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
